// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: sequences TLBP/TLBR/TLBWI/TLBWR against a single-port TLB entry RAM and maintains Random
module tlb_op_sequencer #(
    parameter int ENTRIES = 32,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       tlb_op,
    input  logic             tlb_probe,
    input  logic [31:0]      entry_hi_in,
    input  logic [31:0]      entry_lo0_in,
    input  logic [31:0]      entry_lo1_in,
    input  logic [31:0]      page_mask_in,
    input  logic [31:0]      index_in,
    input  logic [4:0]       wired_in,
    input  logic             wired_write,
    output logic             busy,
    output logic             done,
    output logic [31:0]      index_out,
    output logic [31:0]      entry_hi_out,
    output logic [31:0]      entry_lo0_out,
    output logic [31:0]      entry_lo1_out,
    output logic [31:0]      page_mask_out,
    output logic [4:0]       random_out,
    output logic [IDX_W-1:0] ram_addr,
    output logic             ram_we,
    output logic [95:0]      ram_wdata,
    input  logic [95:0]      ram_rdata
);
    typedef enum logic [2:0] {IDLE, PROBE, RD_ADDR, RD_DATA, WRITE, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W:0]   CNT_END = (IDX_W + 1)'(ENTRIES);

    state_t            state_q, state_d;
    logic [95:0]       ent_q, ent_d;
    logic [IDX_W-1:0]  idx_q, idx_d, rnd_q, rnd_d;
    logic [IDX_W:0]    cnt_q, cnt_d;
    logic [31:0]       index_q, index_d, hi_q, hi_d, lo0_q, lo0_d, lo1_q, lo1_d, mask_q, mask_d;
    logic              hit, probe_end, unused_bits;

    // cnt_q is the probe address; read data for entry cnt_q-1 is on ram_rdata, so cnt_q==0 has nothing to compare
    assign hit = cnt_q != '0
                 && ((ram_rdata[79:61] ^ ent_q[79:61]) & ~{3'b0, ram_rdata[95:80]}) == 19'd0
                 && (ram_rdata[52] || ram_rdata[60:53] == ent_q[60:53]);
    assign probe_end = hit || cnt_q == CNT_END;
    assign unused_bits = ^{entry_hi_in[12:8], entry_lo0_in[31:26], entry_lo1_in[31:26],
                           page_mask_in[31:29], page_mask_in[12:0], index_in[31:IDX_W]};

    // All state; reset abandons any op in flight and restores Random to the top entry
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ent_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rnd_q   <= LAST;
            index_q <= '0;
            hi_q    <= '0;
            lo0_q   <= '0;
            lo1_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rnd_q   <= rnd_d;
            index_q <= index_d;
            hi_q    <= hi_d;
            lo0_q   <= lo0_d;
            lo1_q   <= lo1_d;
            mask_q  <= mask_d;
        end
    end

    // Next state: probe takes priority over a simultaneous op; strobes outside IDLE are ignored
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:           state_d = tlb_probe ? PROBE : tlb_op == 2'b01 ? RD_ADDR : tlb_op[1] ? WRITE : IDLE;
            PROBE:          state_d = probe_end ? DONE : PROBE;
            RD_ADDR:        state_d = RD_DATA;
            RD_DATA, WRITE: state_d = DONE;
            default:        state_d = IDLE;
        endcase
    end

    // Operand latch, probe counter, result capture and Random update
    always_comb begin
        ent_d   = ent_q;
        idx_d   = idx_q;
        index_d = index_q;
        hi_d    = hi_q;
        lo0_d   = lo0_q;
        lo1_d   = lo1_q;
        mask_d  = mask_q;
        cnt_d   = state_q == PROBE ? cnt_q + 1'b1 : '0;
        if (state_q == IDLE && (tlb_probe || tlb_op != 2'b00)) begin
            ent_d = {page_mask_in[28:13], entry_hi_in[31:13], entry_hi_in[7:0],
                     entry_lo0_in[0] & entry_lo1_in[0], entry_lo0_in[25:0], entry_lo1_in[25:0]};
            idx_d = !tlb_probe && tlb_op == 2'b11 ? rnd_q : index_in[IDX_W-1:0];
        end
        if (state_q == PROBE && probe_end)
            index_d = hit ? 32'(cnt_q - 1'b1) : 32'h8000_0000;
        if (state_q == RD_DATA) begin
            hi_d   = {ram_rdata[79:61], 5'b0, ram_rdata[60:53]};
            lo0_d  = {6'b0, ram_rdata[51:27], ram_rdata[52]};
            lo1_d  = {6'b0, ram_rdata[25:1], ram_rdata[52]};
            mask_d = {3'b0, ram_rdata[95:80], 13'b0};
        end
        rnd_d = (wired_write || 32'(wired_in) >= ENTRIES || 32'(rnd_q) <= 32'(wired_in)) ? LAST : rnd_q - 1'b1;
    end

    // Outputs decoded from state; a write is suppressed in the very cycle reset is asserted
    always_comb begin
        busy      = state_q != IDLE;
        done      = state_q == DONE;
        ram_we    = state_q == WRITE && !rst;
        ram_addr  = state_q == PROBE ? cnt_q[IDX_W-1:0] : (state_q == RD_ADDR || state_q == WRITE) ? idx_q : '0;
        ram_wdata = ent_q;
    end

    assign index_out     = index_q;
    assign entry_hi_out  = hi_q;
    assign entry_lo0_out = lo0_q;
    assign entry_lo1_out = lo1_q;
    assign page_mask_out = mask_q;
    assign random_out    = 5'(rnd_q);
endmodule
